// File: rtl/comando_pkg.sv
// Shared definitions for the Bluetooth command decoder: byte codes, FSM states,
// directions and the direction-to-output mapping.
package comando_pkg;

  localparam logic [7:0] ByteFrenteMai   = 8'h57;
  localparam logic [7:0] ByteFrenteMin   = 8'h77;
  localparam logic [7:0] ByteTrasMai     = 8'h53;
  localparam logic [7:0] ByteTrasMin     = 8'h73;
  localparam logic [7:0] ByteDireitaMai  = 8'h44;
  localparam logic [7:0] ByteDireitaMin  = 8'h64;
  localparam logic [7:0] ByteEsquerdaMai = 8'h41;
  localparam logic [7:0] ByteEsquerdaMin = 8'h61;
  localparam logic [7:0] ByteStopMai     = 8'h58;
  localparam logic [7:0] ByteStopMin     = 8'h78;

  typedef enum logic [1:0] {PARADO, MOVENDO, PAUSA} estado_e;

  typedef enum logic [1:0] {FRENTE, TRAS, DIREITA, ESQUERDA} dir_e;

  typedef enum logic [1:0] {CmdMove, CmdStop, CmdErro} tipo_e;

  typedef struct packed {
    tipo_e tipo;
    dir_e  dir;
  } cmd_t;

  function automatic cmd_t decodifica_byte(input logic [7:0] b);
    cmd_t c;
    c.tipo = CmdMove;
    c.dir  = FRENTE;
    case (b)
      ByteFrenteMai, ByteFrenteMin:     c.dir  = FRENTE;
      ByteTrasMai, ByteTrasMin:         c.dir  = TRAS;
      ByteDireitaMai, ByteDireitaMin:   c.dir  = DIREITA;
      ByteEsquerdaMai, ByteEsquerdaMin: c.dir  = ESQUERDA;
      ByteStopMai, ByteStopMin:         c.tipo = CmdStop;
      default:                          c.tipo = CmdErro;
    endcase
    return c;
  endfunction

  // Bit order: {esquerda, direita, tras, frente}.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    return oh;
  endfunction

endpackage

// File: rtl/temporizador_carga.sv
// Loadable down-counter that holds at zero; shared by the watchdog and the dead-time.
module temporizador_carga #(
  parameter int unsigned Largura = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carga,
  input  logic [Largura-1:0] valor,
  output logic               fim
);

  logic [Largura-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carga) begin
      cnt_d = valor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == '0);

endmodule

// File: rtl/decodificador_comando.sv
// Turns UART command bytes into one-hot direction lines, with a link watchdog and a
// dead-time between opposing movements.
module decodificador_comando
  import comando_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS  = 25_000_000,
  parameter int unsigned DEADTIME_CICLOS = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dado,
  input  logic       dado_valido,
  output logic       frente,
  output logic       tras,
  output logic       direita,
  output logic       esquerda,
  output logic       parado,
  output logic       erro_cmd,
  output logic       timeout
);

  localparam int unsigned MaxCiclos = (TIMEOUT_CICLOS > DEADTIME_CICLOS) ?
                                      TIMEOUT_CICLOS : DEADTIME_CICLOS;
  localparam int unsigned LargCnt   = $clog2(MaxCiclos);
  // Counter reads zero in the last cycle of the interval, hence the minus one.
  localparam logic [LargCnt-1:0] CargaWd = LargCnt'(TIMEOUT_CICLOS - 1);
  localparam logic [LargCnt-1:0] CargaDt = LargCnt'(DEADTIME_CICLOS - 1);

  estado_e          estado_q, estado_d;
  dir_e             dir_q, dir_d;      // current direction in MOVENDO, pending in PAUSA
  logic [3:0]       oh_q, oh_d;
  logic             parado_q, parado_d;
  logic             erro_q, erro_d;
  logic             timeout_q, timeout_d;

  cmd_t             cmd;
  logic             mov, stop;
  logic             carga, fim;
  logic [LargCnt-1:0] valor;

  temporizador_carga #(
    .Largura(LargCnt)
  ) u_temporizador (
    .clk  (clk),
    .reset(reset),
    .carga(carga),
    .valor(valor),
    .fim  (fim)
  );

  always_comb begin
    cmd       = decodifica_byte(dado);
    mov       = dado_valido && (cmd.tipo == CmdMove);
    stop      = dado_valido && (cmd.tipo == CmdStop);
    erro_d    = dado_valido && (cmd.tipo == CmdErro);
    estado_d  = estado_q;
    dir_d     = dir_q;
    carga     = 1'b0;
    valor     = CargaWd;
    timeout_d = 1'b0;

    unique case (estado_q)
      PARADO: begin
        if (mov) begin
          estado_d = MOVENDO;
          dir_d    = cmd.dir;
          carga    = 1'b1;
        end
      end
      MOVENDO: begin
        // A command in the expiry cycle takes priority over the watchdog.
        if (stop) begin
          estado_d = PARADO;
        end else if (mov && (cmd.dir == dir_q)) begin
          carga = 1'b1;
        end else if (mov) begin
          estado_d = PAUSA;
          dir_d    = cmd.dir;
          carga    = 1'b1;
          valor    = CargaDt;
        end else if (fim) begin
          estado_d  = PARADO;
          timeout_d = 1'b1;
        end
      end
      PAUSA: begin
        if (mov) begin
          dir_d = cmd.dir;
        end
        if (stop) begin
          estado_d = PARADO;
        end else if (fim) begin
          estado_d = MOVENDO;
          carga    = 1'b1;
        end
      end
      default: estado_d = PARADO;
    endcase

    oh_d     = (estado_d == MOVENDO) ? dir_onehot(dir_d) : 4'b0000;
    parado_d = (oh_d == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q  <= PARADO;
      dir_q     <= FRENTE;
      oh_q      <= 4'b0000;
      parado_q  <= 1'b1;
      erro_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      dir_q     <= dir_d;
      oh_q      <= oh_d;
      parado_q  <= parado_d;
      erro_q    <= erro_d;
      timeout_q <= timeout_d;
    end
  end

  assign frente   = oh_q[0];
  assign tras     = oh_q[1];
  assign direita  = oh_q[2];
  assign esquerda = oh_q[3];
  assign parado   = parado_q;
  assign erro_cmd = erro_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_decodificador_comando.sv
// Self-checking bench for decodificador_comando: decode table, timed corner cases and
// a randomized run against a deadline-based reference model.
module tb_decodificador_comando;

  localparam int unsigned T = 20;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dado = 8'h00;
  logic       dado_valido = 1'b0;
  logic       frente, tras, direita, esquerda, parado, erro_cmd, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  decodificador_comando #(
    .TIMEOUT_CICLOS (T),
    .DEADTIME_CICLOS(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dado       (dado),
    .dado_valido(dado_valido),
    .frente     (frente),
    .tras       (tras),
    .direita    (direita),
    .esquerda   (esquerda),
    .parado     (parado),
    .erro_cmd   (erro_cmd),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  // Packed as {esquerda, direita, tras, frente, parado, erro_cmd, timeout}.
  function automatic logic [6:0] saidas();
    return {esquerda, direita, tras, frente, parado, erro_cmd, timeout};
  endfunction

  function automatic logic [6:0] esp(input logic [3:0] oh, input logic er, input logic to);
    return {oh, (oh == 4'b0000), er, to};
  endfunction

  task automatic check(input string nome, input logic [6:0] exp);
    logic [6:0] act;
    act = saidas();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (esq,dir,tras,fre,parado,erro,timeout)",
               nome, act, exp);
    end
  endtask

  // Drive inputs for the current cycle, then advance to just after the next edge.
  task automatic tick(input logic rst, input logic v, input logic [7:0] b);
    reset       = rst;
    dado_valido = v;
    dado        = b;
    @(posedge clk);
    #1;
    dado_valido = 1'b0;
    reset       = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
  endtask

  // Reference model: mode 0 stopped, 1 moving, 2 paused; deadlines in absolute cycles.
  int     m_modo = 0;
  int     m_dir = 0;
  longint m_prazo = 0;
  longint m_ciclo = 0;

  function automatic int cod_byte(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
    case (u)
      8'h57:   return 0;
      8'h53:   return 1;
      8'h44:   return 2;
      8'h41:   return 3;
      8'h58:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic modelo(input logic rst, input logic v, input logic [7:0] b,
                        output logic [6:0] exp);
    int   cod;
    logic er, to;
    er = 1'b0;
    to = 1'b0;
    if (!rst) begin
      m_modo = 0;
    end else begin
      cod = v ? cod_byte(b) : -1;
      er  = v && (cod < 0);
      case (m_modo)
        0: if (cod >= 0 && cod < 4) begin
          m_modo = 1; m_dir = cod; m_prazo = m_ciclo + T;
        end
        1: if (cod == 4) m_modo = 0;
           else if (cod >= 0 && cod == m_dir) m_prazo = m_ciclo + T;
           else if (cod >= 0) begin
             m_modo = 2; m_dir = cod; m_prazo = m_ciclo + D;
           end else if (m_ciclo == m_prazo) begin
             m_modo = 0; to = 1'b1;
           end
        default: if (cod == 4) m_modo = 0;
           else begin
             if (cod >= 0) m_dir = cod;
             if (m_ciclo == m_prazo) begin
               m_modo = 1; m_prazo = m_ciclo + T;
             end
           end
      endcase
    end
    m_ciclo++;
    exp = esp((m_modo == 1) ? (4'b0001 << m_dir) : 4'b0000, er, to);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [3:0] oh;
    logic       er;
  } vetor_t;

  vetor_t tab[12];

  localparam logic [3:0] OhF = 4'b0001;
  localparam logic [3:0] OhT = 4'b0010;
  localparam logic [3:0] OhD = 4'b0100;
  localparam logic [3:0] OhE = 4'b1000;
  localparam logic [3:0] Oh0 = 4'b0000;

  initial begin
    logic [7:0] pool [10];
    logic [6:0] e;
    logic       r, v;
    logic [7:0] b;

    tab[0]  = '{8'h57, OhF, 1'b0};
    tab[1]  = '{8'h77, OhF, 1'b0};
    tab[2]  = '{8'h53, OhT, 1'b0};
    tab[3]  = '{8'h73, OhT, 1'b0};
    tab[4]  = '{8'h44, OhD, 1'b0};
    tab[5]  = '{8'h64, OhD, 1'b0};
    tab[6]  = '{8'h41, OhE, 1'b0};
    tab[7]  = '{8'h61, OhE, 1'b0};
    tab[8]  = '{8'h58, Oh0, 1'b0};
    tab[9]  = '{8'h78, Oh0, 1'b0};
    tab[10] = '{8'h5A, Oh0, 1'b1};
    tab[11] = '{8'h00, Oh0, 1'b1};

    // Reset held for three cycles while 'W' is strobed.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 8'h57);
      check("reset_hold", esp(Oh0, 1'b0, 1'b0));
    end

    // Byte decode from PARADO.
    foreach (tab[i]) begin
      tick(1'b0, 1'b0, 8'h00);
      tick(1'b1, 1'b1, tab[i].b);
      check($sformatf("decode_%02h", tab[i].b), esp(tab[i].oh, tab[i].er, 1'b0));
    end

    // Start, refresh 15 cycles later, then watchdog expiry T+1 cycles after refresh.
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h77);
    check("start_frente", esp(OhF, 1'b0, 1'b0));
    idle(14);
    tick(1'b1, 1'b1, 8'h57);
    check("refresh_frente", esp(OhF, 1'b0, 1'b0));
    idle(19);
    check("wd_before_expiry", esp(OhF, 1'b0, 1'b0));
    idle(1);
    check("wd_expiry", esp(Oh0, 1'b0, 1'b1));
    idle(1);
    check("wd_after", esp(Oh0, 1'b0, 1'b0));

    // Direction change with dead-time.
    tick(1'b1, 1'b1, 8'h57);
    tick(1'b1, 1'b1, 8'h53);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("deadtime_low_%0d", k), esp(Oh0, 1'b0, 1'b0));
      idle(1);
    end
    check("deadtime_tras", esp(OhT, 1'b0, 1'b0));

    // 'D' during PAUSA replaces the pending direction without restarting dead-time.
    tick(1'b1, 1'b1, 8'h58);
    tick(1'b1, 1'b1, 8'h57);
    tick(1'b1, 1'b1, 8'h53);
    idle(1);
    tick(1'b1, 1'b1, 8'h44);
    check("pausa_d_n3", esp(Oh0, 1'b0, 1'b0));
    idle(1);
    check("pausa_d_n4", esp(Oh0, 1'b0, 1'b0));
    idle(1);
    check("pausa_d_direita", esp(OhD, 1'b0, 1'b0));

    // 'X' during PAUSA cancels the pending move.
    tick(1'b1, 1'b1, 8'h58);
    tick(1'b1, 1'b1, 8'h57);
    tick(1'b1, 1'b1, 8'h53);
    tick(1'b1, 1'b1, 8'h58);
    check("pausa_x_stop", esp(Oh0, 1'b0, 1'b0));
    idle(4);
    check("pausa_x_stays", esp(Oh0, 1'b0, 1'b0));

    // Movement byte in the dead-time expiry cycle becomes the direction entered.
    tick(1'b1, 1'b1, 8'h57);
    tick(1'b1, 1'b1, 8'h53);
    idle(3);
    tick(1'b1, 1'b1, 8'h61);
    check("dt_collision_esq", esp(OhE, 1'b0, 1'b0));
    tick(1'b1, 1'b1, 8'h58);

    // Bad byte while moving: one-cycle error, watchdog untouched.
    tick(1'b1, 1'b1, 8'h57);
    idle(4);
    tick(1'b1, 1'b1, 8'h5A);
    check("bad_byte_pulse", esp(OhF, 1'b1, 1'b0));
    idle(1);
    check("bad_byte_once", esp(OhF, 1'b0, 1'b0));
    idle(13);
    check("bad_byte_wd_before", esp(OhF, 1'b0, 1'b0));
    idle(1);
    check("bad_byte_wd_expiry", esp(Oh0, 1'b0, 1'b1));

    // Refresh in the exact watchdog expiry cycle.
    tick(1'b1, 1'b1, 8'h57);
    idle(19);
    tick(1'b1, 1'b1, 8'h57);
    check("wd_collision_keep", esp(OhF, 1'b0, 1'b0));
    idle(19);
    check("wd_collision_before", esp(OhF, 1'b0, 1'b0));
    idle(1);
    check("wd_collision_expiry", esp(Oh0, 1'b0, 1'b1));

    // Reset in the middle of PAUSA: pending direction never appears.
    tick(1'b1, 1'b1, 8'h57);
    tick(1'b1, 1'b1, 8'h53);
    tick(1'b0, 1'b0, 8'h00);
    check("reset_mid_pausa", esp(Oh0, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("reset_pending_gone", esp(Oh0, 1'b0, 1'b0));
    end

    // Randomized run against the reference model.
    pool = '{8'h57, 8'h77, 8'h53, 8'h73, 8'h44, 8'h64, 8'h41, 8'h61, 8'h58, 8'h78};
    modelo(1'b0, 1'b0, 8'h00, e);
    tick(1'b0, 1'b0, 8'h00);
    check("rand_reset", e);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 11) == 0);
      b = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      modelo(r, v, b, e);
      tick(r, v, b);
      check($sformatf("rand_%0d", i), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decodificador_comando.md
# decodificador_comando

Converts command bytes from the upstream UART receiver (Bluetooth link) into the one-hot direction lines `frente`, `tras`, `direita`, `esquerda` consumed by the motor controller. A watchdog stops the cart when the link goes silent. A mandatory dead-time separates any change between two movement directions, protecting the H-bridges. The block sits between the UART receiver and the motor controller in the Cyclone Cruiser top level.

## Interface
- `TIMEOUT_CICLOS`, default 25_000_000: clock cycles without a refresh before a forced stop (0.5 s at 50 MHz); legal values ≥ 2.
- `DEADTIME_CICLOS`, default 500_000: clock cycles all direction lines are held low on a direction change (10 ms); legal values ≥ 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `dado`  in  8  received byte; valid only when `dado_valido`=1.
- `dado_valido`  in  1  one-cycle strobe from the UART receiver.
- `frente`  out  1  forward command.
- `tras`  out  1  reverse command.
- `direita`  out  1  right command.
- `esquerda`  out  1  left command.
- `parado`  out  1  high when no direction line is asserted.
- `erro_cmd`  out  1  one-cycle pulse when an unrecognised byte is received.
- `timeout`  out  1  one-cycle pulse when the watchdog forces a stop.

## Operation
- Byte map (case-insensitive):
  - 'W'/'w' (0x57/0x77) → FRENTE
  - 'S'/'s' (0x53/0x73) → TRAS
  - 'D'/'d' (0x44/0x64) → DIREITA
  - 'A'/'a' (0x41/0x61) → ESQUERDA
  - 'X'/'x' (0x58/0x78) → STOP
  - Any other byte → `erro_cmd` pulse. State, timers and pending direction are unchanged.
- At most one direction output is high at any time. `parado` is the NOR of the four direction outputs.
- FSM states:
  - **PARADO** (all direction outputs 0):
    - movement byte → MOVENDO with that direction; watchdog loaded.
    - STOP → stay in PARADO.
  - **MOVENDO** (the current direction's output is 1):
    - same-direction byte → watchdog reloaded.
    - STOP → PARADO.
    - different movement byte → PAUSA; the byte is stored as the pending direction; the dead-time counter is loaded.
    - watchdog reaches end → PARADO, with a `timeout` pulse.
  - **PAUSA** (all direction outputs 0; the watchdog is not running):
    - movement byte → replaces the pending direction; the dead-time counter is NOT restarted.
    - STOP → PARADO; the pending direction is discarded.
    - dead-time expires → MOVENDO with the pending direction; watchdog loaded.
- Simultaneous events:
  - A valid byte in the same cycle as watchdog expiry is processed as if the watchdog had not expired. No `timeout` pulse is produced.
  - A valid byte in the same cycle as dead-time expiry: a movement byte becomes the direction entered; STOP wins over the expiry and goes to PARADO.
- Only one timer is active at a time (MOVENDO uses the watchdog, PAUSA uses the dead-time), so a single shared down-counter is used. Its width is `$clog2(max(TIMEOUT_CICLOS, DEADTIME_CICLOS))`. No wrap-around: the counter holds at zero.

## Timing
- All outputs are registered. A byte strobed in cycle N takes effect on the outputs in cycle N+1. `erro_cmd` is high in cycle N+1 only.
- Watchdog: the last refresh (or entry) in cycle N drops the direction output in cycle N+TIMEOUT_CICLOS+1. `timeout` is high in that same cycle.
- Dead-time: direction outputs are low for exactly DEADTIME_CICLOS cycles, measured from the cycle after the strobe. The new direction appears in cycle N+DEADTIME_CICLOS+1.
- Reset asserted (`reset`=0) at any edge, in any state, including mid-PAUSA or mid-MOVENDO:
  - next cycle: state PARADO; all direction outputs 0; `parado`=1; `erro_cmd`=0; `timeout`=0; counter 0; pending direction cleared.
  - bytes strobed during reset are ignored.

## Structure
- Shared package `comando_pkg` holds:
  - the byte constants;
  - the FSM state enum {PARADO, MOVENDO, PAUSA};
  - a 2-bit direction enum {FRENTE, TRAS, DIREITA, ESQUERDA};
  - the function mapping direction to the 4-bit one-hot output.
- One sub-module, `temporizador_carga`: a loadable down-counter with `carga`, `valor`, and `fim` (asserted at zero), parameterised on width. It is shared by the watchdog and the dead-time.

## Test plan
All scenarios use TIMEOUT_CICLOS=20 and DEADTIME_CICLOS=4.

- **Reset:** hold `reset`=0 for 3 cycles while strobing 'W' → all direction outputs 0, `parado`=1 throughout.
- **Start and watchdog:** strobe 'w' in cycle 10 → `frente`=1 from cycle 11. Refresh 'W' in cycle 25 → `frente` stays 1. No further bytes → `frente`=0 and `timeout`=1 in cycle 46.
- **Direction change:** in MOVENDO-FRENTE, strobe 'S' in cycle N → all outputs 0 for cycles N+1..N+4; `tras`=1 from N+5.
- **PAUSA overrides:**
  - 'D' during PAUSA at N+2 → `direita`=1 at N+5, not `tras`.
  - 'X' during PAUSA instead → stays PARADO, `parado`=1.
- **Bad byte:** strobe 0x5A while moving → `erro_cmd` high for exactly one cycle; direction unchanged; watchdog expiry time unchanged.
- **Collisions:**
  - 'W' strobed in the exact expiry cycle → `frente` stays 1, no `timeout` pulse.
  - `reset`=0 mid-PAUSA → outputs 0 the next cycle, and the pending direction is never driven.
